defuzz_wavg: RTL and testbench

//  Weighted-average (Sugeno singleton) defuzzifier that consumes the 9 rule weights produced by
//  the 3x3 min() rule stage and returns one crisp signed output.

---
 rtl/defuzz_wavg_if.sv | 23 ++
 rtl/defuzz_wavg.sv | 175 +++++++++++++++++
 tb/tb_defuzz_wavg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/defuzz_wavg_if.sv
// rtl/defuzz_wavg_if.sv - input/output handshake bundle for the weighted-average defuzzifier
interface defuzz_wavg_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [9*W-1:0] w_flat;
    logic [9*W-1:0] c_flat;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_y;
    logic           out_zero_w;

    modport slave (
        input  in_valid, w_flat, c_flat, out_ready,
        output in_ready, out_valid, out_y, out_zero_w
    );

    modport master (
        output in_valid, w_flat, c_flat, out_ready,
        input  in_ready, out_valid, out_y, out_zero_w
    );
endinterface

// File: rtl/defuzz_wavg.sv
// rtl/defuzz_wavg.sv - Sugeno weighted-average defuzzifier: serial MAC then serial restoring divide
module defuzz_wavg #(
    parameter int                  W           = 16,
    parameter logic signed [W-1:0] DEFAULT_OUT = '0
) (
    input  logic          clk,
    input  logic          rst,
    defuzz_wavg_if.slave  bus,
    output logic          busy
);
    localparam int NW  = 2*W + 4;
    localparam int DW  = W + 4;
    localparam int ITW = $clog2(NW);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_ZERO  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [NW-1:0] QLIM = {{(NW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  YMAX = {1'b0, {(W-1){1'b1}}};

    logic [2:0]     state_q, state_d;
    logic [W-1:0]   w_q [9];
    logic [W-1:0]   w_d [9];
    logic [W-1:0]   c_q [9];
    logic [W-1:0]   c_d [9];
    logic [3:0]     k_q, k_d;
    logic [NW-1:0]  num_q, num_d;
    logic [DW-1:0]  den_q, den_d;
    logic [NW-1:0]  a_q, a_d;
    logic [DW-1:0]  r_q, r_d;
    logic           neg_q, neg_d;
    logic [ITW-1:0] it_q, it_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_y_q, out_y_d;
    logic           out_zero_q, out_zero_d;

    logic [W-1:0]   wk, ck;
    logic [2*W:0]   prod;
    logic [NW-1:0]  num_sum;
    logic [DW-1:0]  den_sum;
    logic [DW:0]    r_sh;
    logic           q_bit;
    logic [DW:0]    r_sub;
    logic [NW-1:0]  a_nx;
    logic [W-1:0]   y_res;

    // Product is formed at 2W+1 bits; the weight is treated as a non-negative signed value.
    always_comb begin
        wk      = w_q[k_q];
        ck      = c_q[k_q];
        prod    = $signed({{(W+1){1'b0}}, wk}) * $signed({{(W+1){ck[W-1]}}, ck});
        num_sum = num_q + {{3{prod[2*W]}}, prod};
        den_sum = den_q + {4'b0000, wk};
        r_sh    = {r_q, a_q[NW-1]};
        q_bit   = (r_sh >= {1'b0, den_q});
        r_sub   = q_bit ? (r_sh - {1'b0, den_q}) : r_sh;
        a_nx    = {a_q[NW-2:0], q_bit};
        if (neg_q) begin
            y_res = (a_nx > QLIM) ? QLIM[W-1:0] : (~a_nx[W-1:0] + W'(1));
        end else begin
            y_res = (a_nx >= QLIM) ? YMAX : a_nx[W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        c_d         = c_q;
        k_d         = k_q;
        num_d       = num_q;
        den_d       = den_q;
        a_d         = a_q;
        r_d         = r_q;
        neg_d       = neg_q;
        it_d        = it_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < 9; i++) begin
                        w_d[i] = bus.w_flat[i*W +: W];
                        c_d[i] = bus.c_flat[i*W +: W];
                    end
                    num_d   = '0;
                    den_d   = '0;
                    k_d     = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                num_d = num_sum;
                den_d = den_sum;
                if (k_q == 4'd8) begin
                    // Divider works on the magnitude; sign is reapplied to the quotient.
                    neg_d   = num_sum[NW-1];
                    a_d     = num_sum[NW-1] ? (~num_sum + NW'(1)) : num_sum;
                    r_d     = '0;
                    it_d    = '0;
                    state_d = (den_sum == '0) ? S_ZERO : S_DIV;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_ZERO: begin
                out_y_d     = DEFAULT_OUT;
                out_zero_d  = 1'b1;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DIV: begin
                a_d  = a_nx;
                r_d  = r_sub[DW-1:0];
                it_d = it_q + ITW'(1);
                if (it_q == ITW'(NW-1)) begin
                    out_y_d     = y_res;
                    out_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= '0;
                c_q[i] <= '0;
            end
            k_q         <= '0;
            num_q       <= '0;
            den_q       <= '0;
            a_q         <= '0;
            r_q         <= '0;
            neg_q       <= 1'b0;
            it_q        <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            c_q         <= c_d;
            k_q         <= k_d;
            num_q       <= num_d;
            den_q       <= den_d;
            a_q         <= a_d;
            r_q         <= r_d;
            neg_q       <= neg_d;
            it_q        <= it_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_zero_w = out_zero_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_defuzz_wavg.sv
// tb/tb_defuzz_wavg.sv - directed scoreboard bench for defuzz_wavg
module tb_defuzz_wavg;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] y;
        logic         z;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;
    int   cyc;
    int   acc_cyc;
    exp_t sb[$];
    logic [9*W-1:0] wf, cf;

    defuzz_wavg_if #(.W(W)) bus ();

    defuzz_wavg #(.W(W), .DEFAULT_OUT(16'sd0)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_set();
        wf = '0;
        cf = '0;
    endtask

    task automatic set_rule(input int k, input logic [W-1:0] w, input logic [W-1:0] c);
        wf[k*W +: W] = w;
        cf[k*W +: W] = c;
    endtask

    function automatic exp_t model(input logic [9*W-1:0] wv, input logic [9*W-1:0] cv);
        exp_t   e;
        longint num, den, q;
        num = 0;
        den = 0;
        for (int k = 0; k < 9; k++) begin
            num += longint'(wv[k*W +: W]) * longint'($signed(cv[k*W +: W]));
            den += longint'(wv[k*W +: W]);
        end
        if (den == 0) begin
            e.y = '0;
            e.z = 1'b1;
            e.lat = 10;
        end else begin
            q = num / den;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            e.y = q[W-1:0];
            e.z = 1'b0;
            e.lat = 45;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] ey, input logic ez, input int elat, input logic keep_junk);
        exp_t e;
        @(negedge clk);
        bus.w_flat   = wf;
        bus.c_flat   = cf;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
        check("in_ready_before_accept", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (keep_junk) begin
            bus.w_flat = {9{16'h1234}};
            bus.c_flat = {9{16'h7000}};
        end else begin
            bus.in_valid = 1'b0;
        end
        e.y = ey;
        e.z = ez;
        e.lat = elat;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   n;
        int   bad;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_out_y"}, bus.out_y, e.y);
            check({tag, "_zero_w"}, bus.out_zero_w, e.z);
            check({tag, "_latency"}, cyc - acc_cyc, e.lat);
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.out_y !== e.y || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                    bus.out_zero_w !== e.z) bad++;
            end
            check({tag, "_hold_stable"}, bad, 0);
            check({tag, "_in_ready_done"}, bus.in_ready, 0);
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            check({tag, "_valid_dropped"}, bus.out_valid, 0);
            check({tag, "_in_ready_after"}, bus.in_ready, 1);
            check({tag, "_y_retained"}, bus.out_y, e.y);
        end
    endtask

    initial begin
        exp_t m;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.w_flat    = '0;
        bus.c_flat    = '0;
        clear_set();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_y", bus.out_y, 0);
        check("rst_zero_w", bus.out_zero_w, 0);
        check("rst_busy", busy, 0);

        clear_set();
        set_rule(4, 16'hFFFF, 16'd1000);
        send(16'd1000, 1'b0, 45, 1'b0);
        collect("s1", 2);

        clear_set();
        set_rule(0, 16'h8000, 16'hF830);
        set_rule(8, 16'h8000, 16'd4000);
        send(16'd1000, 1'b0, 45, 1'b0);
        collect("s2", 2);

        clear_set();
        for (int k = 0; k < 9; k++) set_rule(k, 16'h0000, 16'h1111 * k);
        send(16'd0, 1'b1, 10, 1'b0);
        collect("s3", 2);

        clear_set();
        set_rule(0, 16'd2, 16'hFFFB);
        set_rule(1, 16'd1, 16'd0);
        send(16'hFFFD, 1'b0, 45, 1'b0);
        collect("s4a", 1);

        clear_set();
        for (int k = 0; k < 9; k++) set_rule(k, 16'hFFFF, 16'h8000);
        send(16'h8000, 1'b0, 45, 1'b0);
        collect("s4b", 1);

        clear_set();
        set_rule(2, 16'd300, 16'd700);
        set_rule(6, 16'd100, 16'hFF38);
        send(16'd475, 1'b0, 45, 1'b1);
        collect("s5", 20);
        @(negedge clk);
        check("s5_busy_idle", busy, 0);

        for (int t = 0; t < 3; t++) begin
            clear_set();
            for (int k = 0; k < 9; k++)
                if ($urandom_range(0, 2) != 0) set_rule(k, 16'($urandom_range(0, 65535)), 16'($urandom));
            m = model(wf, cf);
            send(m.y, m.z, m.lat, 1'b0);
            collect("rnd", 1);
        end

        clear_set();
        set_rule(4, 16'hFFFF, 16'd1000);
        send(16'd1000, 1'b0, 45, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("s6_rst_out_valid", bus.out_valid, 0);
        check("s6_rst_out_y", bus.out_y, 0);
        check("s6_rst_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(16'd1000, 1'b0, 45, 1'b0);
        collect("s6", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
